fetch_queue: RTL and testbench

//  Instruction fetch front end: owns the program counter, drives the byte address into the

---
 rtl/fetch_queue_if.sv | 40 ++++
 rtl/fetch_queue.sv | 80 ++++++++
 tb/tb_fetch_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction ROM port, redirect input and decode stream.
// master = fetch_queue side, slave = environment (ROM, execute, decode).
interface fetch_queue_if #(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned I_WIDTH = 32
);
  logic [A_WIDTH-1:0] imem_addr;
  logic [I_WIDTH-1:0] imem_rdata;
  logic               redirect_valid;
  logic [A_WIDTH-1:0] redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [I_WIDTH-1:0] out_instr;
  logic [A_WIDTH-1:0] out_pc;
  logic [A_WIDTH-1:0] out_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, reads a combinational ROM and queues {instr, pc}.
// Optional FETCH_BYPASS_EN: forwards the ROM word straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned A_WIDTH  = 32,
  parameter int unsigned I_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(32'hBFC00000),
  parameter int unsigned DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [A_WIDTH-1:0] fetch_pc;
  logic [PW:0]        count;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [I_WIDTH-1:0] q_instr [DEPTH];
  logic [A_WIDTH-1:0] q_pc    [DEPTH];

  logic               empty;
  logic               bypass;
  logic               bypass_take;
  logic               q_pop;
  logic               push;
  logic               advance;
  logic [A_WIDTH-1:0] head_pc;

  always_comb begin
    empty = (count == '0);
`ifdef FETCH_BYPASS_EN
    bypass = empty & ~bus.redirect_valid;
`else
    bypass = 1'b0;
`endif
    bypass_take = bypass & bus.out_ready;
    q_pop       = ~empty & bus.out_ready;
    // A pop frees the slot, so a full queue can still accept this cycle's word.
    push        = ~bus.redirect_valid & ((count != FULL) | q_pop) & ~bypass_take;
    advance     = push | bypass_take;
    head_pc     = bypass ? fetch_pc : q_pc[rd_ptr];
  end

  assign bus.imem_addr    = fetch_pc;
  assign bus.out_valid    = ~empty | bypass;
  assign bus.out_instr    = bypass ? bus.imem_rdata : q_instr[rd_ptr];
  assign bus.out_pc       = head_pc;
  assign bus.out_pc_plus4 = head_pc + A_WIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[A_WIDTH-1:2], 2'b00};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (advance) fetch_pc <= fetch_pc + A_WIDTH'(4);
      if (push)    wr_ptr   <= wr_ptr + 1'b1;
      if (q_pop)   rd_ptr   <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(q_pop);
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam int          DEPTH    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fetch_queue_if #(.A_WIDTH(32), .I_WIDTH(32)) bus ();

  fetch_queue #(
    .A_WIDTH (32),
    .I_WIDTH (32),
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  assign bus.imem_rdata = rom(bus.imem_addr);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Async reset asserted mid-cycle; outputs must react before any clock edge.
  task automatic reset_all();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    mq.delete();
    m_pc = RESET_PC;
  endtask

  // One clock: drive inputs, compare against model state, advance model and DUT.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic        ev;
    logic [31:0] epc;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    #1;
    ev  = (mq.size() != 0);
    epc = (mq.size() != 0) ? mq[0].pc : m_pc;
`ifdef FETCH_BYPASS_EN
    if (mq.size() == 0 && !rv) ev = 1'b1;
`endif
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    if (ev) begin
      chk("out_pc", bus.out_pc, epc);
      chk("out_instr", bus.out_instr, rom(epc));
      chk("out_pc_plus4", bus.out_pc_plus4, epc + 32'd4);
    end
    if (ev && rdy && mq.size() != 0) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      m_pc = rpc & 32'hFFFFFFFC;
    end else if (ev && rdy && mq.size() == 0 && epc == m_pc) begin
      // Only reachable with bypass: consumed directly without enqueue.
      m_pc = m_pc + 32'd4;
    end else if (mq.size() < DEPTH) begin
      mq.push_back('{instr: rom(m_pc), pc: m_pc});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_all();

`ifndef FETCH_BYPASS_EN
    vt[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'hBFC00000};
    vt[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hBFC00000, 32'hBFC00004};
    vt[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hBFC00004, 32'hBFC00008};
    vt[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC00008, 32'hBFC0000C};
    vt[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC00008, 32'hBFC00010};
    vt[5]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC00008, 32'hBFC00014};
    vt[6]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC00008, 32'hBFC00018};
    vt[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC00008, 32'hBFC00018};
    vt[8]  = '{1'b1, 32'hBFC00103, 1'b0, 1'b1, 32'hBFC00008, 32'hBFC00018};
    vt[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'hBFC00100};
    vt[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hBFC00100, 32'hBFC00104};
    vt[11] = '{1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, 32'hBFC00104, 32'hBFC00108};
    vt[12] = '{1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFC};
    vt[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFC};
    vt[14] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h00000000};
    vt[15] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00000000, 32'h00000004};
    for (int i = 0; i < 16; i++) begin
      bus.redirect_valid = vt[i].rv;
      bus.redirect_pc    = vt[i].rpc;
      bus.out_ready      = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), bus.out_pc, vt[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), bus.out_instr, rom(vt[i].exp_pc));
        chk($sformatf("vec%0d_plus4", i), bus.out_pc_plus4, vt[i].exp_pc + 32'd4);
      end
      @(posedge clk);
      #1;
    end
`endif

    // Long stall: exactly DEPTH words fetched, address frozen, then drain in order.
    reset_all();
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("stall_addr_frozen", bus.imem_addr, 32'hBFC00010);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1);

    // Full queue under continuous pop, then redirect while full.
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'hBFC00103, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 600; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
      cycle(rv, rpc, ($urandom_range(0, 9) < 6));
    end

    // Mid-stream asynchronous reset, then resume.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
    #2;
    reset_all();
    for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, ($urandom_range(0, 1) == 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
